// File: rtl/regfile_checkpoint_checker.sv
// On-chip self-checker: shadows the register-file write-back port and compares
// one shadow register against an expected value at each programmed cycle checkpoint.
module regfile_checkpoint_checker #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NCHK = 8,
  parameter  int CYCW = 16,
  localparam int RW   = $clog2(NREG),
  localparam int CW   = $clog2(NCHK)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_idx,
  input  logic [CYCW-1:0] cfg_cycle,
  input  logic [RW-1:0]   cfg_reg,
  input  logic [XLEN-1:0] cfg_data,
  input  logic [CW:0]     cfg_num,
  input  logic            start,
  input  logic            wb_en,
  input  logic [RW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            done,
  output logic [CW:0]     pass_cnt,
  output logic [CW:0]     fail_cnt,
  output logic            fail_valid,
  output logic [CW-1:0]   fail_idx,
  output logic [XLEN-1:0] fail_obs,
  output logic            timeout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [CYCW-1:0] cycle;
    logic [RW-1:0]   rsel;
    logic [XLEN-1:0] data;
  } chk_t;

  localparam logic [CW:0]   ONE_P = (CW+1)'(1);
  localparam logic [CYCW-1:0] ONE_C = CYCW'(1);

  state_t                     state, state_nxt;
  chk_t                       tbl [NCHK];
  logic [NREG-1:0][XLEN-1:0]  shadow;
  logic [CYCW-1:0]            cnt;
  logic [CW:0]                ptr, num, ptr_nxt;
  chk_t                       cur;
  logic [XLEN-1:0]            obs;
  logic                       run, chk_fire, cnt_sat, to_fire, go;

  assign run      = (state == RUN);
  assign cur      = tbl[ptr[CW-1:0]];
  assign obs      = shadow[cur.rsel];
  assign chk_fire = run && (ptr < num) && (cnt >= cur.cycle);
  assign cnt_sat  = &cnt;
  assign ptr_nxt  = chk_fire ? ptr + ONE_P : ptr;
  // Timeout is judged after this cycle's check has been accounted for.
  assign to_fire  = run && cnt_sat && (ptr_nxt < num);
  assign go       = start && (state != RUN);

  // Table is deliberately not reset so it survives a reset between runs.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE)
      tbl[cfg_idx] <= '{cycle: cfg_cycle, rsel: cfg_reg, data: cfg_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (ptr == num || to_fire) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow     <= '0;
      cnt        <= '0;
      ptr        <= '0;
      num        <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      fail_obs   <= '0;
      timeout    <= 1'b0;
    end else if (go) begin
      shadow     <= '0;
      cnt        <= '0;
      ptr        <= '0;
      num        <= cfg_num;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      fail_obs   <= '0;
      timeout    <= 1'b0;
    end else if (run) begin
      if (wb_en && wb_addr != '0) shadow[wb_addr] <= wb_data;
      if (!cnt_sat) cnt <= cnt + ONE_C;
      ptr <= ptr_nxt;
      // Compare uses the registered shadow, so a same-cycle write is not seen.
      if (chk_fire) begin
        if (obs == cur.data) begin
          pass_cnt <= pass_cnt + ONE_P;
        end else begin
          fail_cnt <= fail_cnt + ONE_P;
          if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_idx   <= ptr[CW-1:0];
            fail_obs   <= obs;
          end
        end
      end
      if (to_fire) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_checkpoint_checker.sv
// Directed bench for regfile_checkpoint_checker; a second instance with a
// 4-bit cycle counter covers the saturation/timeout path.
module tb_regfile_checkpoint_checker;

  logic        clk, rst;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [15:0] cfg_cycle;
  logic [4:0]  cfg_reg;
  logic [31:0] cfg_data;
  logic [3:0]  cfg_num;
  logic        start, start5;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        busy, done, fail_valid, timeout;
  logic [3:0]  pass_cnt, fail_cnt;
  logic [2:0]  fail_idx;
  logic [31:0] fail_obs;

  logic        busy5, done5, fail_valid5, timeout5;
  logic [3:0]  pass_cnt5, fail_cnt5;
  logic [2:0]  fail_idx5;
  logic [31:0] fail_obs5;

  int checks = 0;
  int errors = 0;

  regfile_checkpoint_checker dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_cycle(cfg_cycle),
    .cfg_reg(cfg_reg), .cfg_data(cfg_data), .cfg_num(cfg_num), .start(start),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_valid(fail_valid),
    .fail_idx(fail_idx), .fail_obs(fail_obs), .timeout(timeout)
  );

  regfile_checkpoint_checker #(.CYCW(4)) dut5 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_cycle(cfg_cycle[3:0]),
    .cfg_reg(cfg_reg), .cfg_data(cfg_data), .cfg_num(cfg_num), .start(start5),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy5), .done(done5),
    .pass_cnt(pass_cnt5), .fail_cnt(fail_cnt5), .fail_valid(fail_valid5),
    .fail_idx(fail_idx5), .fail_obs(fail_obs5), .timeout(timeout5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [15:0] cyc,
                     input logic [4:0] r, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_cycle = cyc; cfg_reg = r; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Returns at the negedge inside RUN cycle 0.
  task automatic go(input logic [3:0] n);
    cfg_num = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && !done; i++) @(negedge clk);
    chk("done_wait", done, 1);
  endtask

  task automatic wait_done5(input int lim);
    for (int i = 0; i < lim && !done5; i++) @(negedge clk);
    chk("done5_wait", done5, 1);
  endtask

  // Starts at cycle 0; entries (2,r0,0),(7,r5,0x55),(7,r6,0x66).
  task automatic t4_stim();
    idle(1);
    step(5'd0, 32'h1234);          // cycle 1: x0 write, must be dropped
    idle(1);
    chk("t4_pass_c3", pass_cnt, 1);
    step(5'd5, 32'h55);            // cycle 3
    idle(3);
    step(5'd6, 32'h66);            // cycle 7: second cyc-7 entry runs at 8, sees it
    chk("t4_pass_c8", pass_cnt, 2);
    idle(1);
    chk("t4_pass_c9", pass_cnt, 3);
    wait_done(10);
    chk("t4_fail", fail_cnt, 0);
    chk("t4_fvalid", fail_valid, 0);
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_cycle = '0; cfg_reg = '0; cfg_data = '0;
    cfg_num = '0; start = 1'b0; start5 = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_counts", {pass_cnt, fail_cnt}, 0);
    chk("rst_fail", {fail_valid, fail_idx, fail_obs, timeout}, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: immediate check of an unwritten register
    cfg(3'd0, 16'd0, 5'd3, 32'h5);
    go(4'd1);
    chk("t1_busy", busy, 1);
    chk("t1_fail_c0", fail_cnt, 0);
    idle(1);
    chk("t1_fail_c1", fail_cnt, 1);
    chk("t1_done_c1", done, 0);
    idle(1);
    chk("t1_done_c2", done, 1);
    chk("t1_busy_c2", busy, 0);
    chk("t1_fidx", fail_idx, 0);
    chk("t1_fobs", fail_obs, 0);
    chk("t1_fvalid", fail_valid, 1);
    chk("t1_pass", pass_cnt, 0);

    // 2: two passing checks
    do_reset();
    cfg(3'd0, 16'd3, 5'd3, 32'h5);
    cfg(3'd1, 16'd5, 5'd10, 32'hA);
    go(4'd2);
    idle(1);
    step(5'd3, 32'h5);             // cycle 1
    step(5'd10, 32'hA);            // cycle 2
    chk("t2_pass_c3", pass_cnt, 0);
    idle(1);
    chk("t2_pass_c4", pass_cnt, 1);
    idle(2);
    chk("t2_pass_c6", pass_cnt, 2);
    wait_done(10);
    chk("t2_fail", fail_cnt, 0);
    chk("t2_fvalid", fail_valid, 0);
    chk("t2_timeout", timeout, 0);

    // 3: same-cycle write is invisible to the check
    do_reset();
    cfg(3'd0, 16'd4, 5'd1, 32'hFF);
    go(4'd1);
    idle(4);
    step(5'd1, 32'hFF);            // cycle 4
    wait_done(10);
    chk("t3a_fail", fail_cnt, 1);
    chk("t3a_fobs", fail_obs, 0);
    cfg(3'd0, 16'd5, 5'd1, 32'hFF); // DONE: write must be ignored
    go(4'd1);
    idle(4);
    step(5'd1, 32'hFF);
    wait_done(10);
    chk("t3b_cfg_in_done", fail_cnt, 1);
    do_reset();
    cfg(3'd0, 16'd5, 5'd1, 32'hFF);
    go(4'd1);
    idle(4);
    step(5'd1, 32'hFF);
    wait_done(10);
    chk("t3c_pass", pass_cnt, 1);
    chk("t3c_fail", fail_cnt, 0);

    // 4: x0 stays zero; entries sharing a cycle run back to back
    do_reset();
    cfg(3'd0, 16'd2, 5'd0, 32'h0);
    cfg(3'd1, 16'd7, 5'd5, 32'h55);
    cfg(3'd2, 16'd7, 5'd6, 32'h66);
    go(4'd3);
    t4_stim();

    // 6: reset mid-run, table retained, cfg during RUN ignored
    go(4'd3);
    idle(1);
    step(5'd0, 32'h1234);
    idle(1);
    step(5'd5, 32'h55);
    cfg(3'd1, 16'd0, 5'd5, 32'hDEAD); // cycle 4, in RUN
    chk("t6_pass_pre", pass_cnt, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_pass", pass_cnt, 0);
    chk("t6_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    go(4'd3);
    t4_stim();

    // 5: 4-bit counter saturates with one check still pending
    do_reset();
    cfg(3'd0, 16'd15, 5'd2, 32'h7);
    cfg(3'd1, 16'd15, 5'd2, 32'h7);
    cfg_num = 4'd2; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    idle(1);
    step(5'd2, 32'h7);
    wait_done5(30);
    chk("t5_timeout", timeout5, 1);
    chk("t5_pass", pass_cnt5, 1);
    chk("t5_fail", fail_cnt5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
